// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter: accepts bytes on a valid/ready
// handshake and launches them one at a time with tx_start pulses paced by tx_ready.
module uart_tx_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              tx_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    state_t            state_reg;
    logic              tx_start_reg;
    logic [7:0]        tx_data_reg;
    logic              overflow_reg;

    logic push;
    logic pop;
    logic full_int;
    logic empty_int;

    assign empty_int = (count_reg == '0);
    assign full_int  = (count_reg == DEPTH_CNT);

    // No pass-through when full: a pop in the same cycle does not open the input.
    assign push = in_valid && !full_int;
    assign pop  = (state_reg == IDLE) && !empty_int && tx_ready;

    assign in_ready = !full_int;
    assign empty    = empty_int;
    assign full     = full_int;
    assign count    = count_reg;
    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;
    assign overflow = overflow_reg;

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (in_valid && !in_ready) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Launch sequencing: a new byte goes out only after tx_ready has been
    // seen low and then high again following the previous launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
            rd_ptr_reg   <= '0;
        end else begin
            tx_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        tx_data_reg  <= mem[rd_ptr_reg];
                        tx_start_reg <= 1'b1;
                        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                        state_reg    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state_reg <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!tx_ready) begin
                        state_reg <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model that drops
// tx_ready for a few cycles after each accepted launch.
module tb_uart_tx_fifo;

    localparam int FRAME = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tx_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;

    logic auto_mode;
    logic tx_ready_man;
    logic never_busy;
    logic model_ready = 1'b1;
    int   busy = 0;

    int checks = 0;
    int errors = 0;
    logic [7:0] launched [$];

    logic armed = 1'b1;
    logic seen_low = 1'b0;
    logic prev_start = 1'b0;

    assign tx_ready = auto_mode ? model_ready : tx_ready_man;

    always #5 clk = ~clk;

    uart_tx_fifo #(.ADDR_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .tx_ready (tx_ready),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_now(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_wait(input logic [7:0] b);
        int t;
        t = 0;
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        push_now(b);
    endtask

    task automatic wait_launches(input int n, input int limit);
        int t;
        t = 0;
        while (launched.size() < n && t < limit) begin
            @(negedge clk);
            t++;
        end
        cyc(20);
    endtask

    // Transmitter model: busy for FRAME cycles after it sees tx_start.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst) busy = 0;
            else if (busy > 0) busy--;
            else if (tx_start && !never_busy) busy = FRAME;
            model_ready = (busy == 0);
        end
    end

    // Launch monitor: records every pulse and checks the pacing invariants.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                armed      = 1'b1;
                seen_low   = 1'b0;
                prev_start = 1'b0;
            end else begin
                if (tx_start) begin
                    check("no_back_to_back", 32'(prev_start), 32'd0);
                    check("ready_cycle_before_launch", 32'(armed), 32'd1);
                    launched.push_back(tx_data);
                    $display("launch data=%02h count=%0d", tx_data, count);
                    armed    = 1'b0;
                    seen_low = 1'b0;
                end else if (!tx_ready) begin
                    seen_low = 1'b1;
                end else if (seen_low) begin
                    armed = 1'b1;
                end
                prev_start = tx_start;
            end
        end
    end

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        auto_mode    = 1'b1;
        tx_ready_man = 1'b1;
        never_busy   = 1'b0;
        cyc(3);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        cyc(2);

        // Single byte
        launched.delete();
        push_now(8'hA5);
        check("single_no_start_yet", 32'(tx_start), 32'd0);
        check("single_count_1", 32'(count), 32'd1);
        cyc(1);
        check("single_start", 32'(tx_start), 32'd1);
        check("single_data", 32'(tx_data), 32'hA5);
        check("single_frame", 32'({1'b1, tx_data, 1'b0}), 32'b1101001010);
        check("single_count_0", 32'(count), 32'd0);
        cyc(1);
        check("single_pulse_end", 32'(tx_start), 32'd0);
        check("single_data_held", 32'(tx_data), 32'hA5);
        wait_launches(1, 50);
        check("single_num_launches", 32'(launched.size()), 32'd1);

        // Burst order
        launched.delete();
        for (int i = 1; i <= 5; i++) push_now(8'(i));
        wait_launches(5, 500);
        check("burst_num_launches", 32'(launched.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("burst_order", 32'(launched[i]), 32'(i + 1));
        check("burst_empty", 32'(empty), 32'd1);

        // Full and overflow
        auto_mode    = 1'b0;
        tx_ready_man = 1'b0;
        launched.delete();
        for (int i = 0; i < 17; i++) begin
            if (i == 15 || i == 16) check("fill_in_ready", 32'(in_ready), (i < 16) ? 32'd1 : 32'd0);
            push_now(8'h10 + 8'(i));
        end
        check("full_count", 32'(count), 32'd16);
        check("full_flag", 32'(full), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("overflow_set", 32'(overflow), 32'd1);
        cyc(3);
        check("overflow_sticky", 32'(overflow), 32'd1);
        check("held_no_launch", 32'(launched.size()), 32'd0);
        tx_ready_man = 1'b1;
        auto_mode    = 1'b1;
        wait_launches(16, 2000);
        check("drain_num_launches", 32'(launched.size()), 32'd16);
        for (int i = 0; i < 16; i++) check("drain_order", 32'(launched[i]), 32'h10 + 32'(i));
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_overflow_still", 32'(overflow), 32'd1);

        // Simultaneous push and pop, then wrap across index 15->0
        auto_mode    = 1'b0;
        tx_ready_man = 1'b0;
        launched.delete();
        push_now(8'h30);
        push_now(8'h31);
        push_now(8'h32);
        check("sim_count_3", 32'(count), 32'd3);
        tx_ready_man = 1'b1;
        push_now(8'h33);
        check("sim_start", 32'(tx_start), 32'd1);
        check("sim_data", 32'(tx_data), 32'h30);
        check("sim_count_kept", 32'(count), 32'd3);
        auto_mode = 1'b1;
        for (int b = 8'h34; b <= 8'h43; b++) push_wait(8'(b));
        wait_launches(20, 3000);
        check("wrap_num_launches", 32'(launched.size()), 32'd20);
        for (int i = 0; i < 20; i++) check("wrap_order", 32'(launched[i]), 32'h30 + 32'(i));
        check("wrap_overflow_still", 32'(overflow), 32'd1);

        // Reset while waiting for the transmitter to finish
        auto_mode    = 1'b0;
        tx_ready_man = 1'b0;
        for (int i = 0; i < 5; i++) push_now(8'h50 + 8'(i));
        check("rstop_count_5", 32'(count), 32'd5);
        tx_ready_man = 1'b1;
        cyc(1);
        check("rstop_start", 32'(tx_start), 32'd1);
        check("rstop_count_4", 32'(count), 32'd4);
        tx_ready_man = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rstop_count_0", 32'(count), 32'd0);
        check("rstop_empty", 32'(empty), 32'd1);
        check("rstop_tx_start", 32'(tx_start), 32'd0);
        check("rstop_overflow", 32'(overflow), 32'd0);
        check("rstop_tx_data", 32'(tx_data), 32'h00);
        check("rstop_in_ready", 32'(in_ready), 32'd1);
        auto_mode = 1'b1;
        launched.delete();
        cyc(20);
        check("rstop_no_pulses", 32'(launched.size()), 32'd0);
        push_now(8'h77);
        check("rstop_push_no_start", 32'(tx_start), 32'd0);
        cyc(1);
        check("rstop_push_start", 32'(tx_start), 32'd1);
        check("rstop_push_data", 32'(tx_data), 32'h77);
        wait_launches(1, 50);
        check("rstop_one_launch", 32'(launched.size()), 32'd1);

        // Stall: transmitter never drops tx_ready after a launch
        launched.delete();
        never_busy = 1'b1;
        push_now(8'h60);
        push_now(8'h61);
        cyc(50);
        check("stall_one_launch", 32'(launched.size()), 32'd1);
        check("stall_data", 32'(launched[0]), 32'h60);
        check("stall_count", 32'(count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and launch controller placed directly upstream of the UART transmitter. It accepts bytes from the system side over a valid/ready handshake and stores them in a circular FIFO. It drains them one at a time into the transmitter using single-cycle `tx_start` pulses paced by the transmitter's `tx_ready` level. The block lets producers burst several bytes without waiting for 10-bit serial frames to complete.

## Interface
Parameters:
- `ADDR_W`, default 4: FIFO address width; depth `DEPTH = 2**ADDR_W` (16).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer has a byte on `in_data`.
- `in_data`  in  8  byte to enqueue.
- `in_ready`  out  1  FIFO can accept; equals `!full` (combinational).
- `tx_ready`  in  1  transmitter idle level; high when a new `tx_start` will be accepted.
- `tx_start`  out  1  registered one-cycle launch pulse to the transmitter.
- `tx_data`  out  8  registered byte; valid and stable while `tx_start` is high and held until the next launch.
- `count`  out  ADDR_W+1  number of bytes stored (0..DEPTH).
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky; set when `in_valid && !in_ready`; cleared only by `rst`.

## Operation
- Storage: `DEPTH` x 8 register array, `wr_ptr` and `rd_ptr` of ADDR_W bits, wrapping naturally from DEPTH-1 to 0. `count` is an explicit register.
- Push: on `in_valid && in_ready`, write `mem[wr_ptr] <= in_data` and increment `wr_ptr`.
- Pop: occurs only in the IDLE launch condition below, reading `mem[rd_ptr]` and incrementing `rd_ptr`.
- Count update: push only → +1; pop only → -1; push and pop in the same cycle → unchanged, both pointers advance.
- Full condition: `in_ready` is 0 even if a pop happens that cycle; there is no same-cycle pass-through when full.
- Empty condition: a byte pushed in cycle N is launchable no earlier than cycle N+1.

Launch FSM (2-bit state):
- IDLE: if `!empty && tx_ready`: `tx_data <= mem[rd_ptr]`, `tx_start <= 1`, pop, go to LAUNCH. Otherwise stay; `tx_start` stays 0.
- LAUNCH: `tx_start <= 0`; go to WAIT_BUSY.
- WAIT_BUSY: if `tx_ready == 0`, go to WAIT_DONE; else stay.
- WAIT_DONE: if `tx_ready == 1`, go to IDLE; else stay.
- Unused encoding: go to IDLE with `tx_start <= 0`.

Invariants:
- `tx_start` is never high for two consecutive cycles.
- A new launch is never issued until `tx_ready` has been seen falling and then rising after the previous launch.

Reset:
- Values: state IDLE, pointers 0, `count` 0, `tx_start` 0, `tx_data` 8'h00, `overflow` 0.
- Resulting outputs: `empty` 1, `full` 0, `in_ready` 1.
- Memory contents are not reset.
- Reset mid-transfer discards all queued bytes. The transmitter shares `rst`, so both blocks return to idle together.

## Timing
- Launch latency: byte pushed at edge N (FIFO empty, transmitter idle) → `tx_start` high during cycle N+1 → N+2.
- Transmitter hand-off:
  - The transmitter samples `tx_start` and `tx_data` in cycle N+1 and drops `tx_ready` from cycle N+2.
  - The FSM reaches WAIT_BUSY in cycle N+2 and WAIT_DONE in cycle N+3.
- Back-to-back: when `tx_ready` rises in cycle M (state WAIT_DONE), the FSM reaches IDLE in cycle M+1. The next `tx_start` is high in cycle M+2 if the FIFO is non-empty.
- Count timing: `count`, `empty`, `full` are registered and reflect all pushes and pops of the previous edge. `in_ready` follows `full` in the same cycle.
- Overflow timing: `overflow` rises one cycle after the rejected `in_valid`.

## Test plan
- Single byte: reset, push 8'hA5 once with transmitter idle → `tx_start` is a one-cycle pulse 1 cycle after the push with `tx_data` = 8'hA5. Serial line carries 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). `count` returns to 0.
- Burst order: push 8'h01..8'h05 on consecutive cycles → exactly 5 `tx_start` pulses with `tx_data` 01,02,03,04,05 in order. Each pulse follows a `tx_ready` low→high transition. `empty` = 1 at end.
- Full and overflow: hold `tx_ready` low and push 17 bytes → `count` = 16, `full` = 1, `in_ready` = 0. The 17th byte is dropped and `overflow` = 1 sticky. After `tx_ready` returns high, exactly 16 bytes drain.
- Simultaneous push and pop: with `count` = 3 and a launch occurring, push in the launch cycle → `count` stays 3. Pointers wrap across index 15→0 over 20 bytes with order preserved.
- Reset mid-operation: `rst` asserted while in WAIT_DONE with `count` = 4 → next cycle state IDLE, `count` 0, `tx_start` 0, `overflow` 0. No further pulses occur until a new push.
- Stall: `tx_ready` held high but never dropped after a launch → FSM stays in WAIT_BUSY and no second `tx_start` is issued.
